sisp_cmd_sequencer: RTL and testbench
=====================================

SISP_CMD_SEQUENCER -- requirements
Module: sisp_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd65535, max WAIT cycles before abort.
REQ-002 SHALL have parameter RESULT_ADDR, default 8'd121, context address read after completion.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake.
REQ-006 SHALL have cmd_mode_i  input  6  SISP mode code; legal values 0-9.
REQ-007 SHALL have cmd_nwr_i  input  4  number of config beats following the command, 0-15.
REQ-008 SHALL have cfg_valid_i / cfg_ready_o  in/out  1/1  config-beat handshake.
REQ-009 SHALL have cfg_addr_i  input  8  and cfg_data_i  input  64  config beat: context address and value.
REQ-010 SHALL have ContextRegAddr_o  output  8, DataIn_o  output  64, DataInReady_o  output  1  SISP write port.
REQ-011 SHALL have sisp_DataOut_i  input  64  and sisp_DataOutReady_i  input  1  SISP result port.
REQ-012 SHALL have rsp_valid_o / rsp_ready_i  out/in  1/1, rsp_data_o  output  64, rsp_err_o  output  1  response.
REQ-013 SHALL have busy_o  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CFG, LAUNCH, READ, CAPTURE, RESP.
REQ-015 All SISP-side outputs SHALL be registered, 1 cycle after the decision that produces them.
REQ-016 IDLE: cmd_ready_o=1; SISP port drives addr 0, data 0, DataInReady_o=0.
REQ-017 On cmd accept: latch mode and nwr, clear beat counter and timeout counter; set illegal flag if mode>9; next state CFG if nwr>0, else LAUNCH (legal) or RESP (illegal).
REQ-018 CFG: cfg_ready_o=1; each accepted beat drives next cycle addr=cfg_addr_i, data=cfg_data_i, DataInReady_o=1, except when illegal flag set (DataInReady_o=0, addr 0, data 0: beats drained, not written).
REQ-019 CFG cycles without cfg_valid_i SHALL drive addr 0, data 0, DataInReady_o=0 and not advance the counter.
REQ-020 After the nwr-th accepted beat: next state LAUNCH if legal, RESP with rsp_err_o=1 if illegal.
REQ-021 LAUNCH: drive addr 0, data {58'b0,mode}, DataInReady_o=1 every cycle until sisp_DataOutReady_i sampled high, then go READ.
REQ-022 Mode 0 SHALL not enter LAUNCH; go directly to RESP with rsp_data_o=0, rsp_err_o=0.
REQ-023 LAUNCH SHALL increment a 16-bit timeout counter per cycle; at TIMEOUT_CYCLES without sisp_DataOutReady_i, go RESP with rsp_data_o=0, rsp_err_o=1.
REQ-024 READ: drive addr RESULT_ADDR, data 0, DataInReady_o=0 for exactly one cycle; CAPTURE: register sisp_DataOut_i into rsp_data_o, go RESP.
REQ-025 RESP: rsp_valid_o=1, rsp_data_o/rsp_err_o stable until rsp_ready_i; on handshake go IDLE, rsp_valid_o=0 next cycle.
REQ-026 cmd_ready_o and cfg_ready_o SHALL be 0 outside IDLE and CFG respectively; simultaneous cmd and cfg valid in IDLE: cfg ignored.
REQ-027 sisp_DataOutReady_i outside LAUNCH SHALL be ignored.
REQ-028 Back-to-back: cmd_ready_o SHALL rise the cycle after RESP handshake (one IDLE cycle minimum).

Reset
REQ-029 reset low SHALL immediately force IDLE, all counters 0, cmd_ready_o=1, cfg_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=0, ContextRegAddr_o=0, DataIn_o=0, DataInReady_o=0.
REQ-030 Reset mid-command SHALL abandon it with no response; unconsumed cfg beats remain the host's responsibility.

Verification
REQ-031 mode 1, nwr 3, beats (106,9),(108,0x1_0000_5019),(114,5) -> three writes in order, then addr 0 data 1 repeated; DataOutReady pulse -> addr 121 read, rsp_data_o = sisp value, err 0.
REQ-032 mode 3, nwr 0, DataOutReady after 20 cycles, sisp_DataOut_i=0x1F_217D -> exactly 20 launch writes, rsp_data_o=0x1F_217D.
REQ-033 mode 12, nwr 2 -> both beats consumed, DataInReady_o never 1, rsp_err_o=1.
REQ-034 TIMEOUT_CYCLES=8, mode 2, no DataOutReady -> 8 launch cycles, rsp_err_o=1, rsp_data_o=0.
REQ-035 cfg_valid_i gapped 2 cycles between beats, rsp_ready_i held low 5 cycles -> idle writes in gaps, response held stable 5 cycles.
REQ-036 reset asserted during LAUNCH -> all outputs at reset values same cycle, no rsp_valid_o.

Source files
------------

// File: rtl/sisp_cmd_sequencer.sv
// SISP command sequencer: accepts a host command, streams its config beats
// into the SISP context registers, launches the mode, and returns the result.
module sisp_cmd_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535,
    parameter logic [7:0]  RESULT_ADDR    = 8'd121
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [5:0]  cmd_mode_i,
    input  logic [3:0]  cmd_nwr_i,

    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [7:0]  cfg_addr_i,
    input  logic [63:0] cfg_data_i,

    output logic [7:0]  ContextRegAddr_o,
    output logic [63:0] DataIn_o,
    output logic        DataInReady_o,

    input  logic [63:0] sisp_DataOut_i,
    input  logic        sisp_DataOutReady_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        rsp_err_o,

    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        LAUNCH,
        READ,
        CAPTURE,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [5:0]  mode_q;
    logic [5:0]  mode_d;
    logic [3:0]  nwr_q;
    logic [3:0]  nwr_d;
    logic [3:0]  beat_q;
    logic [3:0]  beat_d;
    logic [15:0] tmo_q;
    logic [15:0] tmo_d;
    logic        ill_q;
    logic        ill_d;

    logic [7:0]  addr_d;
    logic [63:0] data_d;
    logic        dir_d;
    logic [63:0] rsp_data_d;
    logic        rsp_err_d;

    logic        cmd_fire;
    logic        cfg_fire;
    logic        rsp_fire;
    logic        cmd_ill;
    logic        last_beat;
    logic [16:0] tmo_inc;

    assign cmd_fire  = cmd_valid_i && cmd_ready_o;
    assign cfg_fire  = cfg_valid_i && cfg_ready_o;
    assign rsp_fire  = rsp_valid_o && rsp_ready_i;
    assign cmd_ill   = cmd_mode_i > 6'd9;
    assign last_beat = beat_q == (nwr_q - 4'd1);
    // 17-bit so the default 65535 limit compares without wrapping.
    assign tmo_inc   = {1'b0, tmo_q} + 17'd1;

    // Next-state and next-output decisions; everything lands one edge later.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        nwr_d      = nwr_q;
        beat_d     = beat_q;
        tmo_d      = tmo_q;
        ill_d      = ill_q;
        addr_d     = 8'd0;
        data_d     = 64'd0;
        dir_d      = 1'b0;
        rsp_data_d = rsp_data_o;
        rsp_err_d  = rsp_err_o;

        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    mode_d     = cmd_mode_i;
                    nwr_d      = cmd_nwr_i;
                    beat_d     = 4'd0;
                    tmo_d      = 16'd0;
                    ill_d      = cmd_ill;
                    rsp_data_d = 64'd0;
                    rsp_err_d  = 1'b0;
                    if (cmd_nwr_i != 4'd0) begin
                        state_d = CFG;
                    end else begin
                        unique case (1'b1)
                            cmd_ill: begin
                                state_d   = RESP;
                                rsp_err_d = 1'b1;
                            end
                            (cmd_mode_i == 6'd0): state_d = RESP;
                            default: state_d = LAUNCH;
                        endcase
                    end
                end
            end

            CFG: begin
                if (cfg_fire) begin
                    // Beats of an illegal command are drained, never written.
                    if (!ill_q) begin
                        addr_d = cfg_addr_i;
                        data_d = cfg_data_i;
                        dir_d  = 1'b1;
                    end
                    beat_d = beat_q + 4'd1;
                    if (last_beat) begin
                        unique case (1'b1)
                            ill_q: begin
                                state_d   = RESP;
                                rsp_err_d = 1'b1;
                            end
                            (mode_q == 6'd0): state_d = RESP;
                            default: state_d = LAUNCH;
                        endcase
                    end
                end
            end

            LAUNCH: begin
                if (sisp_DataOutReady_i) begin
                    state_d = READ;
                    addr_d  = RESULT_ADDR;
                end else begin
                    addr_d = 8'd0;
                    data_d = {58'd0, mode_q};
                    dir_d  = 1'b1;
                    tmo_d  = tmo_inc[15:0];
                    if (tmo_inc == {1'b0, TIMEOUT_CYCLES}) begin
                        state_d    = RESP;
                        rsp_data_d = 64'd0;
                        rsp_err_d  = 1'b1;
                    end
                end
            end

            READ: begin
                state_d = CAPTURE;
            end

            CAPTURE: begin
                rsp_data_d = sisp_DataOut_i;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end

            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            mode_q           <= 6'd0;
            nwr_q            <= 4'd0;
            beat_q           <= 4'd0;
            tmo_q            <= 16'd0;
            ill_q            <= 1'b0;
            ContextRegAddr_o <= 8'd0;
            DataIn_o         <= 64'd0;
            DataInReady_o    <= 1'b0;
            rsp_data_o       <= 64'd0;
            rsp_err_o        <= 1'b0;
            cmd_ready_o      <= 1'b1;
            cfg_ready_o      <= 1'b0;
            rsp_valid_o      <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            state_q          <= state_d;
            mode_q           <= mode_d;
            nwr_q            <= nwr_d;
            beat_q           <= beat_d;
            tmo_q            <= tmo_d;
            ill_q            <= ill_d;
            ContextRegAddr_o <= addr_d;
            DataIn_o         <= data_d;
            DataInReady_o    <= dir_d;
            rsp_data_o       <= rsp_data_d;
            rsp_err_o        <= rsp_err_d;
            cmd_ready_o      <= state_d == IDLE;
            cfg_ready_o      <= state_d == CFG;
            rsp_valid_o      <= state_d == RESP;
            busy_o           <= state_d != IDLE;
        end
    end

endmodule

// File: tb/tb_sisp_cmd_sequencer.sv
// Bench for sisp_cmd_sequencer: vector table driven through a scoreboard,
// plus timeout, reset-in-flight and stray-ready sequences.
module tb_sisp_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [5:0]  cmd_mode = 6'd0;
    logic [3:0]  cmd_nwr = 4'd0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_addr = 8'd0;
    logic [63:0] cfg_data = 64'd0;
    logic        dor = 1'b0;
    logic [63:0] sisp_out = 64'd0;
    logic        rsp_ready = 1'b0;

    logic        cmd_ready, cfg_ready, dir, rsp_valid, rsp_err, busy;
    logic [7:0]  ctx_addr;
    logic [63:0] data_in, rsp_data;

    logic        t_cmd_valid = 1'b0;
    logic        t_rsp_ready = 1'b0;
    logic        t_cmd_ready, t_cfg_ready, t_dir, t_rsp_valid, t_rsp_err, t_busy;
    logic [7:0]  t_addr;
    logic [63:0] t_data, t_rsp_data;

    always #5 clk = ~clk;

    sisp_cmd_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_mode_i          (cmd_mode),
        .cmd_nwr_i           (cmd_nwr),
        .cfg_valid_i         (cfg_valid),
        .cfg_ready_o         (cfg_ready),
        .cfg_addr_i          (cfg_addr),
        .cfg_data_i          (cfg_data),
        .ContextRegAddr_o    (ctx_addr),
        .DataIn_o            (data_in),
        .DataInReady_o       (dir),
        .sisp_DataOut_i      (sisp_out),
        .sisp_DataOutReady_i (dor),
        .rsp_valid_o         (rsp_valid),
        .rsp_ready_i         (rsp_ready),
        .rsp_data_o          (rsp_data),
        .rsp_err_o           (rsp_err),
        .busy_o              (busy)
    );

    sisp_cmd_sequencer #(.TIMEOUT_CYCLES(16'd8)) dut_t (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cmd_valid_i         (t_cmd_valid),
        .cmd_ready_o         (t_cmd_ready),
        .cmd_mode_i          (6'd2),
        .cmd_nwr_i           (4'd0),
        .cfg_valid_i         (1'b0),
        .cfg_ready_o         (t_cfg_ready),
        .cfg_addr_i          (8'd0),
        .cfg_data_i          (64'd0),
        .ContextRegAddr_o    (t_addr),
        .DataIn_o            (t_data),
        .DataInReady_o       (t_dir),
        .sisp_DataOut_i      (64'h1234),
        .sisp_DataOutReady_i (1'b0),
        .rsp_valid_o         (t_rsp_valid),
        .rsp_ready_i         (t_rsp_ready),
        .rsp_data_o          (t_rsp_data),
        .rsp_err_o           (t_rsp_err),
        .busy_o              (t_busy)
    );

    typedef struct {
        logic [5:0]  mode;
        logic [3:0]  nwr;
        logic [7:0]  a [3];
        logic [63:0] d [3];
        int          gap;
        int          dly;
        logic [63:0] sisp;
        int          hold;
        logic [63:0] edata;
        logic        eerr;
        int          elaunch;
        int          ereads;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          launch;
        int          reads;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [63:0] d;
    } wr_t;

    exp_t       exp_q[$];
    wr_t        wr_q[$];
    int         ncmp = 0;
    int         nfail = 0;
    int         launch_cnt = 0;
    int         read_cnt = 0;
    logic [5:0] cur_mode = 6'd0;
    vec_t       vecs [8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        ncmp++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(
        input logic [5:0] mode, input logic [3:0] nwr,
        input logic [7:0] a0, input logic [63:0] d0,
        input logic [7:0] a1, input logic [63:0] d1,
        input logic [7:0] a2, input logic [63:0] d2,
        input int gap, input int dly, input logic [63:0] sisp,
        input int hold, input logic [63:0] edata, input logic eerr,
        input int el, input int er);
        vec_t v;
        v.mode = mode; v.nwr = nwr;
        v.a[0] = a0; v.d[0] = d0;
        v.a[1] = a1; v.d[1] = d1;
        v.a[2] = a2; v.d[2] = d2;
        v.gap = gap; v.dly = dly; v.sisp = sisp; v.hold = hold;
        v.edata = edata; v.eerr = eerr; v.elaunch = el; v.ereads = er;
        return v;
    endfunction

    task automatic monitor();
        exp_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                launch_cnt = 0;
                read_cnt = 0;
                continue;
            end
            if (dir && ctx_addr != 8'd0) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 64'(wr_q.size()), 64'd1);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", {56'd0, ctx_addr}, {56'd0, w.a});
                    chk("wr_data", data_in, w.d);
                end
            end
            if (dir && ctx_addr == 8'd0) begin
                launch_cnt++;
                chk("launch_data", data_in, {58'd0, cur_mode});
            end
            if (!dir && ctx_addr == 8'd121) begin
                read_cnt++;
                chk("read_data", data_in, 64'd0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                    chk("launch_count", 64'(launch_cnt), 64'(e.launch));
                    chk("read_count", 64'(read_cnt), 64'(e.reads));
                    chk("writes_left", 64'(wr_q.size()), 64'd0);
                end
                launch_cnt = 0;
                read_cnt = 0;
            end
        end
    endtask

    // sel: 0 cmd_ready, 1 cfg_ready (both end just past the handshake edge),
    // 2 rsp_valid (ends on the negedge where it is seen).
    task automatic wait_hi(input string nm, input int sel);
        int   t;
        logic s;
        t = 0;
        do begin
            @(negedge clk);
            s = (sel == 0) ? cmd_ready : ((sel == 1) ? cfg_ready : rsp_valid);
            t++;
        end while (!s && t < 200);
        if (!s) chk({nm, "_timeout"}, {63'd0, s}, 64'd1);
        if (sel < 2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        wr_t  w;
        int   n;
        int   t;
        n = int'(v.nwr);
        cur_mode = v.mode;
        sisp_out = v.sisp;
        if (v.mode <= 6'd9) begin
            for (int i = 0; i < n; i++) begin
                w.a = v.a[i];
                w.d = v.d[i];
                wr_q.push_back(w);
            end
        end
        e.data = v.edata; e.err = v.eerr;
        e.launch = v.elaunch; e.reads = v.ereads;
        exp_q.push_back(e);

        cmd_mode = v.mode;
        cmd_nwr = v.nwr;
        cmd_valid = 1'b1;
        wait_hi("cmd_ready", 0);
        cmd_valid = 1'b0;

        for (int i = 0; i < n; i++) begin
            cfg_addr = v.a[i];
            cfg_data = v.d[i];
            cfg_valid = 1'b1;
            wait_hi("cfg_ready", 1);
            cfg_valid = 1'b0;
            if (i < n - 1) begin
                repeat (v.gap) begin
                    @(posedge clk);
                    #1;
                    chk("gap_idle", {55'd0, dir, ctx_addr}, 64'd0);
                end
            end
        end

        if (v.dly > 0) begin
            t = 0;
            while (launch_cnt < v.dly && t < 300) begin
                @(negedge clk);
                #1;
                t++;
            end
            chk("dor_wait", 64'(launch_cnt), 64'(v.dly));
            dor = 1'b1;
            @(posedge clk);
            #1;
            dor = 1'b0;
        end

        wait_hi("rsp_valid", 2);
        repeat (v.hold) begin
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_data", rsp_data, v.edata);
            chk("hold_err", {63'd0, rsp_err}, {63'd0, v.eerr});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("b2b_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("b2b_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("idle_cfg_ready", {63'd0, cfg_ready}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
        chk({tag, "_cfg_ready"}, {63'd0, cfg_ready}, 64'd0);
        chk({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_data"}, rsp_data, 64'd0);
        chk({tag, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_addr"}, {56'd0, ctx_addr}, 64'd0);
        chk({tag, "_data_in"}, data_in, 64'd0);
        chk({tag, "_dir"}, {63'd0, dir}, 64'd0);
    endtask

    initial begin
        int t;
        int cnt;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        chk("rst_t_cmd_ready", {63'd0, t_cmd_ready}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vecs[0] = mk(6'd1, 4'd3, 8'd106, 64'd9, 8'd108, 64'h1_0000_5019,
                     8'd114, 64'd5, 0, 5, 64'hDEAD_BEEF_0123_4567, 0,
                     64'hDEAD_BEEF_0123_4567, 1'b0, 5, 1);
        vecs[1] = mk(6'd3, 4'd0, 8'd0, 64'd0, 8'd0, 64'd0, 8'd0, 64'd0,
                     0, 20, 64'h1F_217D, 0, 64'h1F_217D, 1'b0, 20, 1);
        vecs[2] = mk(6'd12, 4'd2, 8'd10, 64'd1, 8'd11, 64'd2, 8'd0, 64'd0,
                     0, 0, 64'hFFFF, 0, 64'd0, 1'b1, 0, 0);
        vecs[3] = mk(6'd9, 4'd2, 8'd20, 64'hAA, 8'd21, 64'hBB, 8'd0, 64'd0,
                     2, 3, 64'h55, 5, 64'h55, 1'b0, 3, 1);
        vecs[4] = mk(6'd0, 4'd0, 8'd0, 64'd0, 8'd0, 64'd0, 8'd0, 64'd0,
                     0, 0, 64'h77, 0, 64'd0, 1'b0, 0, 0);
        vecs[5] = mk(6'd0, 4'd1, 8'd30, 64'd7, 8'd0, 64'd0, 8'd0, 64'd0,
                     0, 0, 64'h77, 0, 64'd0, 1'b0, 0, 0);
        vecs[6] = mk(6'd63, 4'd0, 8'd0, 64'd0, 8'd0, 64'd0, 8'd0, 64'd0,
                     0, 0, 64'h77, 2, 64'd0, 1'b1, 0, 0);
        vecs[7] = mk(6'd10, 4'd0, 8'd0, 64'd0, 8'd0, 64'd0, 8'd0, 64'd0,
                     0, 0, 64'h77, 0, 64'd0, 1'b1, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Launch timeout on the 8-cycle instance.
        t_cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!t_cmd_ready && t < 50);
        @(posedge clk);
        #1;
        t_cmd_valid = 1'b0;
        t = 0;
        cnt = 0;
        do begin
            @(negedge clk);
            if (t_dir && t_addr == 8'd0) begin
                cnt++;
                chk("tmo_launch_data", t_data, 64'd2);
            end
            t++;
        end while (!t_rsp_valid && t < 50);
        chk("tmo_rsp_valid", {63'd0, t_rsp_valid}, 64'd1);
        chk("tmo_launch_count", 64'(cnt), 64'd8);
        chk("tmo_rsp_err", {63'd0, t_rsp_err}, 64'd1);
        chk("tmo_rsp_data", t_rsp_data, 64'd0);
        @(posedge clk);
        #1;
        t_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        t_rsp_ready = 1'b0;
        @(negedge clk);
        chk("tmo_b2b_cmd_ready", {63'd0, t_cmd_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Reset while launching: abandon, no response.
        cur_mode = 6'd2;
        cmd_mode = 6'd2;
        cmd_nwr = 4'd0;
        cmd_valid = 1'b1;
        wait_hi("cmd_ready", 0);
        cmd_valid = 1'b0;
        t = 0;
        while (launch_cnt < 3 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("mid_launch_reached", 64'(launch_cnt), 64'd3);
        chk("mid_launch_busy", {63'd0, busy}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            chk("post_rst_busy", {63'd0, busy}, 64'd0);
        end

        // Stray DataOutReady while idle is ignored.
        @(posedge clk);
        #1;
        dor = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_dor_busy", {63'd0, busy}, 64'd0);
            chk("idle_dor_dir", {55'd0, dir, ctx_addr}, 64'd0);
        end
        dor = 1'b0;

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 ncmp, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "global timeout");
    end

endmodule
